// File: rtl/sayeh_ctrl_pkg.sv
// Shared constants for the SAYEH control path: word width, fetch FSM state
// encodings and the default reset vector.
package sayeh_ctrl_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEF_RESET_VECTOR = 16'h0000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VECTOR  = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_LOAD_IR = 3'd3;
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_UPDATE  = 3'd5;
    localparam logic [2:0] ST_HALT    = 3'd6;

endpackage

// File: rtl/fetch_timeout_counter.sv
// 8-bit wait counter for the FETCH state. The terminal flag means the
// current enabled cycle is the one that brings the count up to LIMIT.
module fetch_timeout_counter #(
    parameter int LIMIT = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_last = i_en && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// SAYEH instruction-fetch sequencer: walks the PC through vector load,
// memory fetch, IR load, execute wait and PC update.
module fetch_sequencer
    import sayeh_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [WORD_W-1:0] PC_INC       = 16'd1,
    parameter int                MEM_TIMEOUT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_halt_req,
    input  logic [WORD_W-1:0] i_pc_cur,
    output logic [WORD_W-1:0] o_pc_next,
    output logic              o_pc_en,
    output logic              o_mem_read,
    input  logic              i_mem_ready,
    output logic              o_ir_load,
    input  logic              i_exec_done,
    input  logic              i_branch_taken,
    input  logic [WORD_W-1:0] i_branch_target,
    output logic              o_halted,
    output logic              o_fault,
    output logic [2:0]        o_state
);

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_pc_next;
    logic              r_fault;
    logic              r_halt_pend;

    logic w_in_fetch;
    logic w_to_last;

    assign w_in_fetch = (r_state == ST_FETCH);

    // Ready on the terminal cycle clears the counter, so ready beats timeout.
    fetch_timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!w_in_fetch || i_mem_ready),
        .i_en    (w_in_fetch),
        .o_last  (w_to_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pc_next   <= '0;
            r_fault     <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_VECTOR;
                        r_pc_next <= RESET_VECTOR;
                    end
                end
                ST_VECTOR: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= ST_LOAD_IR;
                    end else if (w_to_last) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end
                end
                ST_LOAD_IR: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (i_exec_done) begin
                        r_pc_next   <= i_branch_taken ? i_branch_target : i_pc_cur + PC_INC;
                        r_halt_pend <= i_halt_req;
                        r_state     <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_state     <= r_halt_pend ? ST_HALT : ST_FETCH;
                    r_halt_pend <= 1'b0;
                end
                ST_HALT: begin
                    // Resume at the current PC; a faulted sequencer needs reset.
                    if (i_start && !r_fault) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_pc_next  = r_pc_next;
    assign o_pc_en    = (r_state == ST_VECTOR) || (r_state == ST_UPDATE);
    assign o_mem_read = w_in_fetch;
    assign o_ir_load  = (r_state == ST_LOAD_IR);
    assign o_halted   = (r_state == ST_HALT);
    assign o_fault    = r_fault;
    assign o_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: the bench owns the PC register and
// predicts every PC from the address arithmetic and the fetch protocol.
module tb_fetch_sequencer;

    localparam logic [15:0] RV = 16'h0000;
    localparam int          TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] pc_cur = 16'h0000;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        mem_read;
    logic        mem_ready = 1'b0;
    logic        ir_load;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halted;
    logic        fault;
    logic [2:0]  state_o;

    logic [3:0]  strobes;
    logic [15:0] model_pc;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pcen = 0;

    assign strobes = {pc_en, mem_read, ir_load, halted};

    fetch_sequencer #(
        .RESET_VECTOR (RV),
        .PC_INC       (16'd1),
        .MEM_TIMEOUT  (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_halt_req      (halt_req),
        .i_pc_cur        (pc_cur),
        .o_pc_next       (pc_next),
        .o_pc_en         (pc_en),
        .o_mem_read      (mem_read),
        .i_mem_ready     (mem_ready),
        .o_ir_load       (ir_load),
        .i_exec_done     (exec_done),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_halted        (halted),
        .o_fault         (fault),
        .o_state         (state_o)
    );

    always #5 clk = ~clk;

    // PC register: captures pc_next on the negedge inside a pc_en cycle.
    always @(negedge clk) begin
        if (pc_en === 1'b1) begin
            pc_cur <= pc_next;
            n_pcen <= n_pcen + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction, entered in the first FETCH cycle.
    task automatic run_instr(input int mwait, input int ewait, input bit br,
                             input logic [15:0] tgt, input bit hreq);
        logic [15:0] exp_pc;
        n_checks++;
        if (pc_cur !== model_pc || strobes !== 4'b0100 || state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL fetch_entry: pc_cur=%h strobes=%b state=%0d, expected pc=%h strobes=0100 state=2",
                     pc_cur, strobes, state_o, model_pc);
        end
        for (int w = 0; w < mwait; w++) begin
            mem_ready = 1'b0;
            tick();
            n_checks++;
            if (strobes !== 4'b0100 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d]: strobes=%b fault=%b, expected 0100 fault=0", w, strobes, fault);
            end
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (strobes !== 4'b0010 || state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL ir_load: strobes=%b state=%0d, expected 0010 state=3", strobes, state_o);
        end
        tick();
        for (int w = 0; w <= ewait; w++) begin
            n_checks++;
            if (strobes !== 4'b0000 || state_o !== 3'd4) begin
                n_fail++;
                $display("FAIL exec_wait[%0d]: strobes=%b state=%0d, expected 0000 state=4", w, strobes, state_o);
            end
            if (w < ewait) begin
                exec_done     = 1'b0;
                branch_taken  = 1'($urandom);
                halt_req      = 1'($urandom);
                branch_target = 16'($urandom);
            end else begin
                exec_done     = 1'b1;
                branch_taken  = br;
                branch_target = tgt;
                halt_req      = hreq;
            end
            tick();
        end
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        halt_req     = 1'b0;
        exp_pc = br ? tgt : 16'((int'(model_pc) + 1) % 65536);
        n_checks++;
        if (strobes !== 4'b1000 || pc_next !== exp_pc) begin
            n_fail++;
            $display("FAIL pc_update: strobes=%b pc_next=%h, expected 1000 pc_next=%h", strobes, pc_next, exp_pc);
        end
        model_pc = exp_pc;
        tick();
        n_checks++;
        if (hreq ? (strobes !== 4'b0001 || state_o !== 3'd6) : (strobes !== 4'b0100 || state_o !== 3'd2)) begin
            n_fail++;
            $display("FAIL after_update: strobes=%b state=%0d halt_req=%b", strobes, state_o, hreq);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (strobes !== 4'b0000 || fault !== 1'b0 || state_o !== 3'd0 || pc_next !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: strobes=%b fault=%b state=%0d pc_next=%h, expected 0000 0 0 0000",
                     strobes, fault, state_o, pc_next);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (state_o !== 3'd0 || strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d strobes=%b, expected 0 0000", state_o, strobes);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (strobes !== 4'b1000 || pc_next !== RV || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL vector: strobes=%b pc_next=%h state=%0d, expected 1000 %h 1", strobes, pc_next, state_o, RV);
        end
        model_pc = RV;
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(0, 0, 1'b0, 16'h0000, 1'b0);
        run_instr(0, 0, 1'b0, 16'h0000, 1'b0);
        run_instr(0, 0, 1'b1, 16'h0040, 1'b0);
        n_checks++;
        if (pc_cur !== 16'h0040 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_fetch: pc_cur=%h mem_read=%b, expected 0040 1", pc_cur, mem_read);
        end
    endtask

    task automatic test_wrap();
        run_instr(1, 2, 1'b1, 16'hFFFF, 1'b0);
        run_instr(0, 0, 1'b0, 16'h0000, 1'b0);
        n_checks++;
        if (pc_cur !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: pc_cur=%h, expected 0000", pc_cur);
        end
    endtask

    task automatic test_random();
        run_instr(TO - 1, 0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 25; i++) begin
            run_instr($urandom_range(0, TO - 1), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
        end
    endtask

    task automatic test_halt_resume();
        run_instr(0, 1, 1'b1, 16'h0010, 1'b0);
        run_instr(0, 0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (strobes !== 4'b0001 || state_o !== 3'd6 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold: strobes=%b state=%0d fault=%b, expected 0001 6 0", strobes, state_o, fault);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (strobes !== 4'b0100 || state_o !== 3'd2 || pc_cur !== 16'h0011) begin
            n_fail++;
            $display("FAIL resume: strobes=%b state=%0d pc_cur=%h, expected 0100 2 0011", strobes, state_o, pc_cur);
        end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            n_checks++;
            if (strobes !== 4'b0100 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: strobes=%b fault=%b, expected 0100 0", i, strobes, fault);
            end
        end
        tick();
        n_checks++;
        if (strobes !== 4'b0001 || fault !== 1'b1 || state_o !== 3'd6) begin
            n_fail++;
            $display("FAIL timeout_fault: strobes=%b fault=%b state=%0d, expected 0001 1 6", strobes, fault, state_o);
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (strobes !== 4'b0001 || fault !== 1'b1 || state_o !== 3'd6) begin
                n_fail++;
                $display("FAIL fault_start_ignored: strobes=%b fault=%b state=%0d", strobes, fault, state_o);
            end
        end
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (fault !== 1'b0 || state_o !== 3'd0 || strobes !== 4'b0000) begin
            n_fail++;
            $display("FAIL fault_reset: fault=%b state=%0d strobes=%b, expected 0 0 0000", fault, state_o, strobes);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [15:0] pc_before;
        int          pcen_before;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pc_before   = pc_cur;
        pcen_before = n_pcen;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (strobes !== 4'b0100) begin
                n_fail++;
                $display("FAIL mid_fetch_wait: strobes=%b, expected 0100", strobes);
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #6;
        n_checks++;
        if (strobes !== 4'b0000 || state_o !== 3'd0 || pc_cur !== pc_before || n_pcen != pcen_before) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: strobes=%b state=%0d pc_cur=%h pc_en_pulses=%0d, expected 0000 0 %h %0d",
                     strobes, state_o, pc_cur, n_pcen - pcen_before, pc_before, 0);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_pc = RV;
        tick();
        run_instr(2, 1, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_random();
        test_halt_resume();
        test_timeout();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the SAYEH instruction-fetch loop. Sequences the 16-bit program counter register through four steps: reset vector, memory fetch, IR load, and PC update.
- Drives the PC register's `in`/`enable` pair, the memory read strobe and the IR load strobe.
- Handshakes with the execute controller through `exec_done` and the branch inputs.
- Sits between the control unit and the PC/IR/memory datapath.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on start after reset.
- PC_INC, 16'd1, PC increment for a non-branch instruction.
- MEM_TIMEOUT, 8, cycles FETCH waits for mem_ready before declaring a fault (range 1..255).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin or resume fetching (level, sampled in IDLE/HALT).
- halt_req  input  1  stop after the current instruction.
- pc_cur  input  16  PC register output; also used as the memory address.
- pc_next  output  16  value for the PC register `in`.
- pc_en  output  1  PC register `enable`; the PC captures pc_next on the negedge inside the pc_en cycle.
- mem_read  output  1  memory read strobe.
- mem_ready  input  1  memory data valid.
- ir_load  output  1  IR capture strobe (1-cycle pulse).
- exec_done  input  1  execute stage finished the current instruction.
- branch_taken  input  1  valid with exec_done; redirects the PC.
- branch_target  input  16  target address, valid with branch_taken.
- halted  output  1  sequencer is in HALT.
- fault  output  1  sticky memory-timeout flag.
- state_o  output  3  current FSM state, for debug.

Behaviour:
- States, with encodings: IDLE=0, VECTOR=1, FETCH=2, LOAD_IR=3, EXEC=4, UPDATE=5, HALT=6.
- All outputs are Moore, decoded from registered state and registers.
- Reset (rst_n=0 at posedge):
  - state=IDLE, pc_next=16'h0000, pc_en=0, mem_read=0, ir_load=0, halted=0, fault=0, timeout counter=0.
  - Reset in any state takes effect at that posedge and aborts any in-flight fetch; no partial PC update occurs.
- IDLE: start=1 -> VECTOR.
- VECTOR: pc_next=RESET_VECTOR, pc_en=1 for exactly one cycle -> FETCH.
- FETCH:
  - mem_read=1 and the counter increments each cycle.
  - mem_ready=1 -> LOAD_IR, counter cleared.
  - Counter reaching MEM_TIMEOUT with mem_ready=0 -> fault=1, then HALT.
  - mem_ready on the same cycle the counter reaches the limit: ready wins, no fault.
- LOAD_IR: ir_load=1 for one cycle, mem_read=0 -> EXEC.
- EXEC:
  - Holds until exec_done=1.
  - On exec_done, registers pc_next: branch_taken ? branch_target : pc_cur+PC_INC (mod 2^16; 16'hFFFF+1 wraps to 16'h0000).
  - Registers halt_req into a pending flag, then goes to UPDATE.
  - branch_taken and halt_req are ignored unless exec_done=1.
- UPDATE: pc_en=1 for one cycle -> HALT if the halt flag is pending, else FETCH. pc_cur is valid at the first FETCH cycle.
- HALT:
  - halted=1, all strobes 0.
  - start=1 with fault=0 -> FETCH (resume at current PC, no vector reload).
  - With fault=1, start is ignored; only reset clears the fault.
- Latency:
  - exec_done (cycle N) -> pc_en at N+1 -> mem_read at N+2.
  - A minimum instruction with zero-wait memory and exec_done in the first EXEC cycle takes 4 cycles.
- Invariants:
  - pc_en, ir_load and mem_read are mutually exclusive.
  - pc_en never lasts more than one cycle.

Decomposition:
- Shared package `sayeh_ctrl_pkg` holds:
  - state encoding constants (3-bit localparams);
  - the width constant WORD_W=16;
  - RESET_VECTOR default.
- One natural sub-module, `fetch_timeout_counter`: an 8-bit counter with clear, enable and terminal flag at MEM_TIMEOUT.
- Everything else lives in the FSM.

Test Plan:
- Reset then start=1, memory always ready, exec_done every EXEC cycle, no branches:
  - pc_en pulses with pc_next = 0000, 0001, 0002, 0003.
  - mem_read and ir_load each pulse once per instruction.
  - Period is 4 cycles.
- Branch: at pc_cur=0005, exec_done=1, branch_taken=1, branch_target=16'h0040 -> next pc_en cycle carries pc_next=0040, and the following FETCH has pc_cur=0040.
- Wrap: drive pc_cur=FFFF, exec_done=1, branch_taken=0 -> pc_next=0000.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> after 8 FETCH cycles fault=1, halted=1, state_o=6. start is then ignored until rst_n=0, which gives fault=0 and state IDLE.
- Halt/resume:
  - halt_req=1 with exec_done at pc_cur=0010 -> pc_en with pc_next=0011, then halted=1.
  - start=1 -> FETCH with no VECTOR pass; the first mem_read sees pc_cur=0011.
- Reset mid-FETCH: rst_n=0 on the 3rd FETCH cycle -> next posedge mem_read=0, state IDLE, and no pc_en pulse has occurred.
